// File: rtl/clock_monitor.sv
// Purpose: measures period and high time of an asynchronous divided clock (sense_clk) in clock_in cycles, with lock and stall detection.
// Latency: edges are seen 3 cycles after sense_clk moves; period/high_time/period_valid appear the cycle after a rise detection.
// Backpressure: none; period_valid is a single-cycle strobe that must be consumed when it fires.
// Optional build macro CLKMON_TOLERANCE_EN: periods within +/-1 count as matching (default build: exact match only).
module clock_monitor #(
   parameter int CNT_W      = 16,
   parameter int LOCK_COUNT = 4
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             sense_clk,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int                 MATCH_W = ($clog2(LOCK_COUNT + 1) < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

   state_t             state_q, state_d;
   logic [2:0]         sync_q, sync_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic               valid_q, valid_d;
   logic               locked_q, locked_d;
   logic               timeout_q, timeout_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               first_q, first_d;

   logic               rise_det;
   logic               fall_det;
   logic [CNT_W-1:0]   cnt_inc;
   logic [MATCH_W-1:0] match_inc;
   logic               is_match;

   // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the delayed copy for edge detection
   assign rise_det  =  sync_q[1] & ~sync_q[2];
   assign fall_det  = ~sync_q[1] &  sync_q[2];
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign match_inc = (match_q == LOCK_M) ? match_q : match_q + MATCH_W'(1);

`ifdef CLKMON_TOLERANCE_EN
   logic [CNT_W-1:0] period_diff;

   // new period counts as matching when it is within one cycle of the previous one
   always_comb begin
      period_diff = (cnt_inc >= period_q) ? (cnt_inc - period_q) : (period_q - cnt_inc);
      is_match    = (period_diff <= CNT_W'(1));
   end
`else
   assign is_match = (cnt_inc == period_q);
`endif

   // next-state, measurement capture and lock tracking; clear outranks any edge seen this cycle
   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[1:0], sense_clk};
      cnt_d     = cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      match_d   = match_q;
      first_d   = first_q;

      if (clear) begin
         state_d   = IDLE;
         cnt_d     = '0;
         timeout_d = 1'b0;
         locked_d  = 1'b0;
         match_d   = '0;
         first_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_det) begin
                  state_d = MEASURE;
                  cnt_d   = '0;
               end
            end
            MEASURE: begin
               cnt_d = cnt_inc;
               if (fall_det) begin
                  high_d = cnt_inc;
               end
               if (rise_det) begin
                  period_d = cnt_inc;
                  cnt_d    = '0;
                  valid_d  = 1'b1;
                  if (first_q) begin
                     // no previous period to compare against yet
                     first_d = 1'b0;
                     match_d = '0;
                  end else if (is_match) begin
                     match_d  = match_inc;
                     locked_d = (match_inc == LOCK_M);
                  end else begin
                     match_d  = '0;
                     locked_d = 1'b0;
                  end
               end else if (cnt_inc == CNT_MAX) begin
                  state_d   = STALLED;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  match_d   = '0;
                  first_d   = 1'b1;
               end
            end
            STALLED: begin
               if (rise_det) begin
                  state_d = MEASURE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // state register with synchronous active-high reset
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         cnt_q     <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         match_q   <= '0;
         first_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         match_q   <= match_d;
         first_q   <= first_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period counter and of the measurement outputs.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: number of consecutive matching periods required to assert locked.
REQ-003 SHALL have port clock_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sense_clk, input, 1 bit: the divided clock under measurement, asynchronous to clock_in.
REQ-006 SHALL have port clear, input, 1 bit: restarts measurement and clears the sticky timeout flag.
REQ-007 SHALL have port period, output, CNT_W bits: clock_in cycles between the last two rise detections.
REQ-008 SHALL have port high_time, output, CNT_W bits: clock_in cycles from a rise detection to the following fall detection.
REQ-009 SHALL have port period_valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-010 SHALL have port locked, output, 1 bit: asserted while the measured period is stable.
REQ-011 SHALL have port timeout, output, 1 bit: sticky flag indicating sense_clk stopped.

Function
REQ-012 SHALL sample sense_clk through a 2-flop synchronizer, then detect edges by comparing against a third registered copy, giving 3 cycles of detection latency.
REQ-013 SHALL implement states IDLE, MEASURE and STALLED.
REQ-014 SHALL, in IDLE, on a rise detection, zero the counter, go to MEASURE and emit no period_valid.
REQ-015 SHALL, in MEASURE, increment the counter every cycle, saturating at 2^CNT_W-1.
REQ-016 SHALL, on a fall detection in MEASURE, capture high_time as the cycle count since the last rise detection.
REQ-017 SHALL, on a rise detection in MEASURE, load period with the cycle count since the previous rise detection, restart counting, and pulse period_valid in the cycle after detection.
REQ-018 SHALL, when the counter reaches 2^CNT_W-1 in MEASURE, go to STALLED, set timeout, and clear locked and the match count.
REQ-019 SHALL, on a rise detection in STALLED, go to MEASURE with a zeroed counter and no period_valid; timeout SHALL remain set.
REQ-020 SHALL keep a match count: the first period_valid after IDLE or STALLED sets the count to 0.
REQ-021 SHALL increment the match count on each later period that matches the previous period, and reset it to 0 on a mismatch.
REQ-022 SHALL assert locked in the same cycle as the period_valid at which the match count reaches LOCK_COUNT, holding the count saturated there.
REQ-023 SHALL deassert locked in the same cycle as a mismatching period_valid.
REQ-024 SHALL, on clear, go to IDLE and zero timeout, locked, the match count and the counter; period and high_time SHALL hold their values.
REQ-025 SHALL give clear priority over a simultaneous edge detection, with no period_valid that cycle.
REQ-026 SHALL give reset priority over clear.

Reset
REQ-027 SHALL, while reset is high, at each clock edge drive period=0, high_time=0, period_valid=0, locked=0, timeout=0, state=IDLE, and clear the synchronizer, counter and match count.
REQ-028 SHALL, when reset is asserted mid-measurement, discard the partial count; the first period_valid SHALL then require two fresh rise detections.

Configuration
REQ-029 SHALL support the macro CLKMON_TOLERANCE_EN.
REQ-030 SHALL, with CLKMON_TOLERANCE_EN defined, count a period as matching when |period - previous period| <= 1.
REQ-031 SHALL, with CLKMON_TOLERANCE_EN undefined, count a period as matching only on exact equality.

Verification
REQ-032 SHALL cover: a divide-by-18 50% sense_clk after reset -> the first period_valid follows the second rise, with period=18 and high_time=9; locked rises at the 5th period_valid.
REQ-033 SHALL cover: switching to divide-by-20 while locked -> the next valid gives period=20 and high_time=10, locked falls that cycle, and relocks 4 valids later.
REQ-034 SHALL cover: sense_clk held low -> timeout=1 and locked=0 after 65535 counted cycles; after restart, timeout stays 1 until a clear pulse, then reads 0.
REQ-035 SHALL cover: clear coincident with a rise detection -> no period_valid; the next valid comes only after two further rises.
REQ-036 SHALL cover: reset pulsed mid-period -> all outputs read 0 the next cycle and the state is IDLE.
REQ-037 SHALL cover: periods alternating 18/19 -> locked after 5 valids with CLKMON_TOLERANCE_EN, never locked without it.
